// File: rtl/cdc_fifo_pkg.sv
// Shared constants and pointer type for the dual-clock FIFO read/write state blocks.
package cdc_fifo_pkg;
  localparam int unsigned DEFAULT_ADDRESS_WIDTH = 4;
  localparam int unsigned MIN_SYNC_STAGES       = 2;

  typedef logic [DEFAULT_ADDRESS_WIDTH-1:0] ptr_t;
endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary to reflected-Gray converter.
module binary_to_gray #(
  parameter int unsigned ADDRESS_WIDTH = 4
) (
  input  logic [ADDRESS_WIDTH-1:0] binary,
  output logic [ADDRESS_WIDTH-1:0] gray
);
  assign gray = binary ^ (binary >> 1);
endmodule

// File: rtl/cdc_gray_sync.sv
// N-stage synchroniser chain for a Gray-coded pointer crossing into this clock domain.
module cdc_gray_sync
  import cdc_fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);
  // Never build a chain shorter than the metastability floor.
  localparam int DEPTH = (STAGES < MIN_SYNC_STAGES) ? int'(MIN_SYNC_STAGES) : int'(STAGES);

  logic [WIDTH-1:0] chain_q [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) chain_q[i] <= '0;
    end else begin
      chain_q[0] <= async_in;
      for (int i = 1; i < DEPTH; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign sync_out = chain_q[DEPTH-1];
endmodule

// File: rtl/gray_to_binary.sv
// Combinational reflected-Gray to binary converter.
module gray_to_binary #(
  parameter int unsigned ADDRESS_WIDTH = 4
) (
  input  logic [ADDRESS_WIDTH-1:0] gray,
  output logic [ADDRESS_WIDTH-1:0] binary
);
  // Binary bit i is the parity of all Gray bits at or above i.
  for (genvar i = 0; i < ADDRESS_WIDTH; i++) begin : g_bit
    assign binary[i] = ^gray[ADDRESS_WIDTH-1:i];
  end
endmodule

// File: rtl/cdc_fifo_write_state.sv
// Write-domain pointer manager: binary/Gray write pointer, synchronised read pointer,
// full/almost_full/free_slots and a sticky overflow flag.
module cdc_fifo_write_state
  import cdc_fifo_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH         = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned ALMOST_FULL_THRESHOLD = 2,
  parameter int unsigned SYNC_STAGES           = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     write,
  input  logic [ADDRESS_WIDTH-1:0] read_address_gray,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [ADDRESS_WIDTH-1:0] write_address_gray,
  output logic                     full,
  output logic                     almost_full,
  output logic [ADDRESS_WIDTH-1:0] free_slots,
  output logic                     overflow,
  input  logic                     overflow_clear
);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDRESS_WIDTH-1:0] read_gray_sync;
  logic [ADDRESS_WIDTH-1:0] read_address_sync;
  logic [ADDRESS_WIDTH-1:0] write_address_next;
  logic [ADDRESS_WIDTH-1:0] write_address_gray_next;

  cdc_gray_sync #(
    .WIDTH  (ADDRESS_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_read_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .async_in (read_address_gray),
    .sync_out (read_gray_sync)
  );

  gray_to_binary #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_read_decode (
    .gray   (read_gray_sync),
    .binary (read_address_sync)
  );

  assign write_address_next = write_address + PTR_ONE;

  binary_to_gray #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_write_encode (
    .binary (write_address_next),
    .gray   (write_address_gray_next)
  );

  // One slot stays empty so that equal pointers always mean empty, never full.
  assign full         = (write_address_next == read_address_sync);
  assign free_slots   = read_address_sync - write_address - PTR_ONE;
  assign almost_full  = (32'(free_slots) <= ALMOST_FULL_THRESHOLD);
  assign write_enable = write & ~full;

  // Gray pointer is loaded from the encoded next value so the crossing sees a flop output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_address      <= '0;
      write_address_gray <= '0;
    end else if (write_enable) begin
      write_address      <= write_address_next;
      write_address_gray <= write_address_gray_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (write & full) begin
      overflow <= 1'b1;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end
  end
endmodule
